conv_loop_ctrl: RTL

CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

---
 rtl/acc_ctrl_pkg.sv | 21 ++
 rtl/conv_loop_ctrl_if.sv | 62 ++++++
 rtl/loop_counter.sv | 43 ++++
 rtl/conv_loop_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accelerator loop controller: default counter
// widths, FSM state encoding and the read-stride helper.
package acc_ctrl_pkg;

  localparam int unsigned DefRowW  = 7;
  localparam int unsigned DefFeatW = 4;
  localparam int unsigned DefFiltW = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } ctrl_state_e;

  // Read-side step for the row/column counters.
  function automatic logic [1:0] read_step(input logic stride2);
    return stride2 ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/conv_loop_ctrl_if.sv
// Configuration, handshake and counter bus of conv_loop_ctrl.
// Stride2 exists only when CONV_CTRL_STRIDE_EN is defined.
interface conv_loop_ctrl_if
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W  = DefRowW,
  parameter int unsigned FEAT_W = DefFeatW,
  parameter int unsigned FILT_W = DefFiltW
) ();

  logic              Start;
  logic              Stall;
  logic [1:0]        R_Start;
  logic [1:0]        W_Start;
  logic [ROW_W-1:0]  R_Final_Row;
  logic [ROW_W-1:0]  W_Final_Row;
  logic [FEAT_W-1:0] Final_Feature;
  logic [FILT_W-1:0] Final_Filter;
  logic [FILT_W-1:0] Depth_EN;
`ifdef CONV_CTRL_STRIDE_EN
  logic              Stride2;
`endif
  logic              Wr_Valid;

  logic [FEAT_W-1:0] Feature_Counter;
  logic [FILT_W-1:0] R_Filter_Counter;
  logic [FILT_W-1:0] W_Filter_Counter;
  logic [ROW_W-1:0]  R_Row_Counter;
  logic [ROW_W-1:0]  R_Col_Counter;
  logic [ROW_W-1:0]  W_Row_Counter;
  logic [ROW_W-1:0]  W_Col_Counter;
  logic              R_Valid;
  logic              Busy;
  logic              Depth_Start;
  logic              R_Done;
  logic              W_Done;

  // Side that drives configuration and consumes counters.
  modport master (
    output Start, Stall, R_Start, W_Start, R_Final_Row, W_Final_Row,
    output Final_Feature, Final_Filter, Depth_EN, Wr_Valid,
`ifdef CONV_CTRL_STRIDE_EN
    output Stride2,
`endif
    input  Feature_Counter, R_Filter_Counter, W_Filter_Counter,
    input  R_Row_Counter, R_Col_Counter, W_Row_Counter, W_Col_Counter,
    input  R_Valid, Busy, Depth_Start, R_Done, W_Done
  );

  // Controller side.
  modport slave (
    input  Start, Stall, R_Start, W_Start, R_Final_Row, W_Final_Row,
    input  Final_Feature, Final_Filter, Depth_EN, Wr_Valid,
`ifdef CONV_CTRL_STRIDE_EN
    input  Stride2,
`endif
    output Feature_Counter, R_Filter_Counter, W_Filter_Counter,
    output R_Row_Counter, R_Col_Counter, W_Row_Counter, W_Col_Counter,
    output R_Valid, Busy, Depth_Start, R_Done, W_Done
  );

endinterface

// File: rtl/loop_counter.sv
// Wrapping loop counter: loads start_i, advances by step_i when enabled and
// wraps back to start_i once the next step would pass final_i.
module loop_counter #(
  parameter int unsigned Width = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] start_i,
  input  logic [Width-1:0] final_i,
  input  logic [1:0]       step_i,
  output logic [Width-1:0] count_o,
  output logic             last_o
);

  logic [Width-1:0] count_q, count_d;
  logic [Width:0]   next_wide;

  // One extra bit so the overshoot compare cannot wrap.
  always_comb begin
    next_wide = {1'b0, count_q} + {{(Width - 1){1'b0}}, step_i};
    last_o    = next_wide > {1'b0, final_i};
    count_d   = count_q;
    if (load_i) begin
      count_d = start_i;
    end else if (en_i) begin
      count_d = last_o ? start_i : next_wide[Width-1:0];
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/conv_loop_ctrl.sv
// Convolution loop controller: nested read address counters (feature, column,
// row, filter) and an independent write-back position tracker, sequenced by
// an IDLE/READ/DRAIN/DONE FSM.
// Optional feature: define CONV_CTRL_STRIDE_EN for the Stride2 input and
// stride-2 read stepping; otherwise the read stride is fixed at 1.
module conv_loop_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W  = DefRowW,
  parameter int unsigned FEAT_W = DefFeatW,
  parameter int unsigned FILT_W = DefFiltW
) (
  input logic             clk,
  input logic             RST,
  conv_loop_ctrl_if.slave bus_io
);

  ctrl_state_e       state_q;
  logic [1:0]        r_start_q, w_start_q;
  logic [ROW_W-1:0]  r_final_q, w_final_q;
  logic [FEAT_W-1:0] final_feat_q;
  logic [FILT_W-1:0] final_filt_q, depth_en_q;
  logic              w_done_seen_q, depth_seen_q;
`ifdef CONV_CTRL_STRIDE_EN
  logic              stride2_q;
`endif

  logic              idle, start_acc, r_valid, w_acc;
  logic              r_done, w_done, depth_start;
  logic [1:0]        r_step;
  logic [ROW_W-1:0]  r_start_row, w_start_row;

  logic [FEAT_W-1:0] r_feat;
  logic [FILT_W-1:0] r_filt, w_filt;
  logic [ROW_W-1:0]  r_col, r_row, w_col, w_row;
  logic              r_feat_last, r_col_last, r_row_last, r_filt_last;
  logic              w_col_last, w_row_last, w_filt_last;

`ifdef CONV_CTRL_STRIDE_EN
  assign r_step = read_step(stride2_q);
`else
  assign r_step = read_step(1'b0);
`endif

  assign idle      = (state_q == StIdle);
  assign start_acc = idle & bus_io.Start;

  // Counters load on the Start edge, before the config registers hold the
  // new values, so the start index is taken straight from the bus in IDLE.
  assign r_start_row = {{(ROW_W - 2){1'b0}}, (idle ? bus_io.R_Start : r_start_q)};
  assign w_start_row = {{(ROW_W - 2){1'b0}}, (idle ? bus_io.W_Start : w_start_q)};

  assign r_valid = (state_q == StRead) & ~bus_io.Stall;
  assign w_acc   = bus_io.Wr_Valid & ((state_q == StRead) | (state_q == StDrain));

  assign r_done = r_valid & r_feat_last & r_col_last & r_row_last & r_filt_last;
  // The wrap of all three write counters coincides with W_Done, which returns
  // them to their initial position on the next edge.
  assign w_done = w_acc & w_col_last & w_row_last & w_filt_last;
  assign depth_start = w_acc & w_col_last & w_row_last & (w_filt == depth_en_q) &
                       (depth_en_q <= final_filt_q) & ~depth_seen_q;

  loop_counter #(.Width(FEAT_W)) u_r_feat (
    .clk_i   (clk),
    .rst_ni  (RST),
    .load_i  (start_acc),
    .en_i    (r_valid),
    .start_i ('0),
    .final_i (final_feat_q),
    .step_i  (2'd1),
    .count_o (r_feat),
    .last_o  (r_feat_last)
  );

  loop_counter #(.Width(ROW_W)) u_r_col (
    .clk_i   (clk),
    .rst_ni  (RST),
    .load_i  (start_acc),
    .en_i    (r_valid & r_feat_last),
    .start_i (r_start_row),
    .final_i (r_final_q),
    .step_i  (r_step),
    .count_o (r_col),
    .last_o  (r_col_last)
  );

  loop_counter #(.Width(ROW_W)) u_r_row (
    .clk_i   (clk),
    .rst_ni  (RST),
    .load_i  (start_acc),
    .en_i    (r_valid & r_feat_last & r_col_last),
    .start_i (r_start_row),
    .final_i (r_final_q),
    .step_i  (r_step),
    .count_o (r_row),
    .last_o  (r_row_last)
  );

  loop_counter #(.Width(FILT_W)) u_r_filt (
    .clk_i   (clk),
    .rst_ni  (RST),
    .load_i  (start_acc),
    .en_i    (r_valid & r_feat_last & r_col_last & r_row_last),
    .start_i ('0),
    .final_i (final_filt_q),
    .step_i  (2'd1),
    .count_o (r_filt),
    .last_o  (r_filt_last)
  );

  loop_counter #(.Width(ROW_W)) u_w_col (
    .clk_i   (clk),
    .rst_ni  (RST),
    .load_i  (start_acc),
    .en_i    (w_acc),
    .start_i (w_start_row),
    .final_i (w_final_q),
    .step_i  (2'd1),
    .count_o (w_col),
    .last_o  (w_col_last)
  );

  loop_counter #(.Width(ROW_W)) u_w_row (
    .clk_i   (clk),
    .rst_ni  (RST),
    .load_i  (start_acc),
    .en_i    (w_acc & w_col_last),
    .start_i (w_start_row),
    .final_i (w_final_q),
    .step_i  (2'd1),
    .count_o (w_row),
    .last_o  (w_row_last)
  );

  loop_counter #(.Width(FILT_W)) u_w_filt (
    .clk_i   (clk),
    .rst_ni  (RST),
    .load_i  (start_acc),
    .en_i    (w_acc & w_col_last & w_row_last),
    .start_i ('0),
    .final_i (final_filt_q),
    .step_i  (2'd1),
    .count_o (w_filt),
    .last_o  (w_filt_last)
  );

  // Layer FSM plus configuration capture and per-layer flags.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      r_start_q     <= '0;
      w_start_q     <= '0;
      r_final_q     <= '0;
      w_final_q     <= '0;
      final_feat_q  <= '0;
      final_filt_q  <= '0;
      depth_en_q    <= '0;
      w_done_seen_q <= 1'b0;
      depth_seen_q  <= 1'b0;
`ifdef CONV_CTRL_STRIDE_EN
      stride2_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.Start) begin
            r_start_q     <= bus_io.R_Start;
            w_start_q     <= bus_io.W_Start;
            r_final_q     <= bus_io.R_Final_Row;
            w_final_q     <= bus_io.W_Final_Row;
            final_feat_q  <= bus_io.Final_Feature;
            final_filt_q  <= bus_io.Final_Filter;
            depth_en_q    <= bus_io.Depth_EN;
            w_done_seen_q <= 1'b0;
            depth_seen_q  <= 1'b0;
`ifdef CONV_CTRL_STRIDE_EN
            stride2_q     <= bus_io.Stride2;
`endif
            state_q       <= StRead;
          end
        end
        StRead: begin
          // Writes can finish before reads; remember it for DRAIN.
          if (w_done) begin
            w_done_seen_q <= 1'b1;
          end
          if (r_done) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (w_done || w_done_seen_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      if (depth_start) begin
        depth_seen_q <= 1'b1;
      end
    end
  end

  assign bus_io.Feature_Counter  = r_feat;
  assign bus_io.R_Filter_Counter = r_filt;
  assign bus_io.W_Filter_Counter = w_filt;
  assign bus_io.R_Row_Counter    = r_row;
  assign bus_io.R_Col_Counter    = r_col;
  assign bus_io.W_Row_Counter    = w_row;
  assign bus_io.W_Col_Counter    = w_col;
  assign bus_io.R_Valid          = r_valid;
  assign bus_io.Busy             = ~idle;
  assign bus_io.Depth_Start      = depth_start;
  assign bus_io.R_Done           = r_done;
  assign bus_io.W_Done           = w_done;

endmodule
